// File: rtl/nibble_packer_pkg.sv
// Shared constants for the nibble packer: state encoding and default word size.
package nibble_packer_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    localparam int DEFAULT_WORD_NIBBLES = 8;
    localparam int COUNT_W              = 4;

endpackage

// File: rtl/nibble_packer.sv
// Nibble packer: pops 4-bit nibbles from an async-read queue and assembles
// them little-endian into a word. A word is presented (held) when it fills
// or when a flush arrives with at least one nibble collected.
module nibble_packer
    import nibble_packer_pkg::*;
#(
    parameter int WORD_NIBBLES = DEFAULT_WORD_NIBBLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                q_dout,
    input  logic                      q_empty,
    output logic                      q_rd_en,
    input  logic                      flush,
    output logic [4*WORD_NIBBLES-1:0] word_out,
    output logic [COUNT_W-1:0]        word_count,
    output logic                      word_valid,
    input  logic                      word_ready,
    output logic                      busy
);

    localparam logic [COUNT_W-1:0] FULL = COUNT_W'(WORD_NIBBLES);

    state_e                    state_q, state_d;
    logic [COUNT_W-1:0]        cnt_q, cnt_d;
    logic [COUNT_W-1:0]        cnt_inc;
    logic [4*WORD_NIBBLES-1:0] word_q, word_d;
    logic [COUNT_W-1:0]        wcnt_q, wcnt_d;
    logic                      valid_q, valid_d;
    logic                      pop;

    // Pop whenever collecting and data is present; reset forces it low.
    assign pop      = !rst && (state_q == COLLECT) && !q_empty;
    assign q_rd_en  = pop;
    assign cnt_inc  = cnt_q + COUNT_W'(1);

    assign word_out   = word_q;
    assign word_count = wcnt_q;
    assign word_valid = valid_q;
    assign busy       = (cnt_q != '0) || valid_q;

    // Next-state: insert popped nibble at the current count, close the word
    // on full or flush, and clear everything once the held word transfers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        wcnt_d  = wcnt_q;
        valid_d = valid_q;
        if (state_q == COLLECT) begin
            if (pop) begin
                for (int k = 0; k < WORD_NIBBLES; k++) begin
                    if (cnt_q == COUNT_W'(k)) word_d[4*k +: 4] = q_dout;
                end
                cnt_d = cnt_inc;
                // A flush with a coincident pop keeps the popped nibble.
                if (cnt_inc == FULL || flush) begin
                    state_d = HOLD;
                    valid_d = 1'b1;
                    wcnt_d  = cnt_inc;
                end
            end else if (flush && cnt_q != '0) begin
                state_d = HOLD;
                valid_d = 1'b1;
                wcnt_d  = cnt_q;
            end
        end else begin
            // Outputs stay frozen until the downstream takes the word.
            if (word_ready) begin
                state_d = COLLECT;
                cnt_d   = '0;
                word_d  = '0;
                wcnt_d  = '0;
                valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset discarding any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            word_q  <= '0;
            wcnt_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            wcnt_q  <= wcnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_nibble_packer.sv
// Directed and random-gap bench for nibble_packer (WORD_NIBBLES = 8).
module tb_nibble_packer;

    logic        clk;
    logic        rst;
    logic [3:0]  q_dout;
    logic        q_empty;
    logic        q_rd_en;
    logic        flush;
    logic [31:0] word_out;
    logic [3:0]  word_count;
    logic        word_valid;
    logic        word_ready;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0]  src[$];
    logic [35:0] cap[$];

    nibble_packer #(.WORD_NIBBLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .q_dout    (q_dout),
        .q_empty   (q_empty),
        .q_rd_en   (q_rd_en),
        .flush     (flush),
        .word_out  (word_out),
        .word_count(word_count),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive inputs (1 after posedge), sample just before the edge,
    // consume the queue head if popped, then settle 1 past the edge.
    task automatic cyc(input bit gap, input bit fl, input bit rdy, output bit popped);
        q_empty    = gap || (src.size() == 0);
        q_dout     = q_empty ? 4'hF : src[0];
        flush      = fl;
        word_ready = rdy;
        #1;
        popped = q_rd_en;
        if (!rst && word_valid && word_ready) cap.push_back({word_count, word_out});
        @(posedge clk);
        if (popped) void'(src.pop_front());
        #1;
    endtask

    task automatic test_reset();
        bit p;
        rst = 1'b1;
        src.push_back(4'h7);
        q_empty = 1'b0;
        q_dout  = 4'h7;
        #1;
        n_chk++;
        if (q_rd_en !== 1'b0) begin $display("FAIL reset_rd_en got %b want 0", q_rd_en); n_fail++; end
        cyc(0, 0, 0, p);
        cyc(0, 0, 0, p);
        n_chk++;
        if (word_valid !== 1'b0 || word_count !== 4'd0 || word_out !== 32'h0 || busy !== 1'b0) begin
            $display("FAIL reset_vals got v=%b c=%0d w=%h b=%b want 0/0/0/0", word_valid, word_count, word_out, busy);
            n_fail++;
        end
        src.delete();
        rst = 1'b0;
    endtask

    task automatic test_full_word();
        bit p;
        cap.delete();
        for (int i = 1; i <= 8; i++) src.push_back(4'(i));
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, p);
        n_chk++;
        if (word_valid !== 1'b0) begin $display("FAIL full_early got %b want 0", word_valid); n_fail++; end
        cyc(0, 0, 1, p);
        n_chk++;
        if (word_valid !== 1'b1 || word_out !== 32'h87654321 || word_count !== 4'd8) begin
            $display("FAIL full_word got v=%b w=%h c=%0d want 1/87654321/8", word_valid, word_out, word_count);
            n_fail++;
        end
        cyc(0, 0, 1, p);
        n_chk++;
        if (word_valid !== 1'b0 || busy !== 1'b0 || word_out !== 32'h0) begin
            $display("FAIL full_after got v=%b b=%b w=%h want 0/0/0", word_valid, busy, word_out);
            n_fail++;
        end
        n_chk++;
        if (cap.size() != 1) begin $display("FAIL full_count got %0d want 1", cap.size()); n_fail++; end
    endtask

    task automatic test_back_to_back();
        bit p;
        bit any_pop;
        bit unstable;
        cap.delete();
        for (int i = 1; i <= 8; i++) src.push_back(4'(i));
        for (int i = 8; i <= 15; i++) src.push_back(4'(i));
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, p);
        any_pop  = 1'b0;
        unstable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, p);
            any_pop |= p;
            if (word_valid !== 1'b1 || word_out !== 32'h87654321 || word_count !== 4'd8) unstable = 1'b1;
        end
        n_chk++;
        if (any_pop) begin $display("FAIL bp_rd_en got pop want none"); n_fail++; end
        n_chk++;
        if (unstable) begin $display("FAIL bp_stable got w=%h want 87654321 held", word_out); n_fail++; end
        cyc(0, 0, 1, p);
        n_chk++;
        if (p !== 1'b0) begin $display("FAIL bp_xfer_pop got 1 want 0"); n_fail++; end
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, p);
        n_chk++;
        if (word_valid !== 1'b1 || word_out !== 32'hFEDCBA98 || word_count !== 4'd8) begin
            $display("FAIL bp_second got v=%b w=%h c=%0d want 1/fedcba98/8", word_valid, word_out, word_count);
            n_fail++;
        end
        cyc(0, 0, 1, p);
        n_chk++;
        if (cap.size() != 2 || cap[0] !== {4'd8, 32'h87654321}) begin
            $display("FAIL bp_stream got n=%0d want 2 words", cap.size());
            n_fail++;
        end
    endtask

    task automatic test_flush();
        bit p;
        src.push_back(4'hA); src.push_back(4'hB); src.push_back(4'hC);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, p);
        cyc(0, 1, 0, p);
        n_chk++;
        if (word_valid !== 1'b1 || word_out !== 32'h00000CBA || word_count !== 4'd3) begin
            $display("FAIL flush_partial got v=%b w=%h c=%0d want 1/00000cba/3", word_valid, word_out, word_count);
            n_fail++;
        end
        // Flush while holding must not disturb the held word.
        cyc(0, 1, 0, p);
        n_chk++;
        if (word_out !== 32'h00000CBA || word_count !== 4'd3) begin
            $display("FAIL flush_in_hold got w=%h c=%0d want 00000cba/3", word_out, word_count);
            n_fail++;
        end
        cyc(0, 0, 1, p);
        cyc(1, 1, 1, p);
        n_chk++;
        if (word_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL flush_empty got v=%b b=%b want 0/0", word_valid, busy);
            n_fail++;
        end
    endtask

    task automatic test_flush_pop();
        bit p;
        src.push_back(4'h1); src.push_back(4'h2); src.push_back(4'h3);
        cyc(0, 0, 0, p);
        cyc(0, 0, 0, p);
        cyc(0, 1, 0, p);
        n_chk++;
        if (word_valid !== 1'b1 || word_out !== 32'h00000321 || word_count !== 4'd3) begin
            $display("FAIL flush_pop got v=%b w=%h c=%0d want 1/00000321/3", word_valid, word_out, word_count);
            n_fail++;
        end
        cyc(0, 0, 1, p);
    endtask

    task automatic test_reset_mid();
        bit p;
        cap.delete();
        for (int i = 0; i < 5; i++) src.push_back(4'h9);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, p);
        rst = 1'b1;
        cyc(1, 0, 1, p);
        rst = 1'b0;
        n_chk++;
        if (busy !== 1'b0) begin $display("FAIL rstmid_busy got %b want 0", busy); n_fail++; end
        for (int i = 1; i <= 8; i++) src.push_back(4'(i));
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, p);
        cyc(0, 0, 1, p);
        n_chk++;
        if (cap.size() != 1 || cap[0] !== {4'd8, 32'h87654321}) begin
            $display("FAIL rstmid_word got n=%0d first=%h want 1 word 887654321", cap.size(),
                     (cap.size() > 0) ? cap[0] : 36'h0);
            n_fail++;
        end
    endtask

    task automatic test_random();
        bit p;
        int budget;
        logic [3:0]  nib[$];
        logic [35:0] exp_w;
        cap.delete();
        src.delete();
        for (int i = 0; i < 1000; i++) begin
            nib.push_back(4'($urandom_range(0, 15)));
            src.push_back(nib[i]);
        end
        budget = 0;
        while (cap.size() < 125 && budget < 20000) begin
            cyc($urandom_range(0, 3) == 0, 0, $urandom_range(0, 2) != 0, p);
            budget++;
        end
        n_chk++;
        if (cap.size() != 125) begin $display("FAIL rand_count got %0d want 125", cap.size()); n_fail++; end
        for (int w = 0; w < 125 && w < cap.size(); w++) begin
            exp_w = {4'd8, 32'h0};
            for (int k = 0; k < 8; k++) exp_w[4*k +: 4] = nib[8*w + k];
            n_chk++;
            if (cap[w] !== exp_w) begin
                $display("FAIL rand_word%0d got %h want %h", w, cap[w], exp_w);
                n_fail++;
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        q_empty    = 1'b1;
        q_dout     = 4'h0;
        flush      = 1'b0;
        word_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_full_word();
        test_back_to_back();
        test_flush();
        test_flush_pop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
